// File: rtl/mac_pkg.sv
// mac_pkg: shared types, widths and helpers for the wallace_mac_accum stage.
//   state_t    - accumulate FSM state (EMPTY, PARTIAL)
//   PROD_W     - width of the 8x8 product
//   cnt_width  - width of a term counter able to hold max_terms
package mac_pkg;

    typedef enum logic {EMPTY, PARTIAL} state_t;

    localparam int PROD_W = 16;

    function automatic int cnt_width(input int max_terms);
        return $clog2(max_terms) + 1;
    endfunction

endpackage

// File: rtl/wallace_mac_accum_if.sv
// wallace_mac_accum_if: operand stream in, group result out, plus clear.
//   master: operand streamer / result consumer side (drives in_*, clear, out_ready)
//   slave : the MAC stage (drives in_ready, out_valid, out_acc, out_count, out_ovf)
//   in_valid/in_ready/in_a/in_b/in_last - operand pair handshake
//   clear                               - synchronous flush of pipeline and partial group
//   out_valid/out_ready                 - result handshake
//   out_acc/out_count/out_ovf           - group sum, term count, sticky overflow
interface wallace_mac_accum_if
    import mac_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = cnt_width(256)
);

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_last;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, clear, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, clear, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_ovf
    );

endinterface

// File: rtl/WallaceTreeMultpr8x8.sv
// WallaceTreeMultpr8x8: combinational unsigned 8x8 multiplier built as a Wallace tree.
//   a, b - unsigned operands
//   prod - 16-bit product
module WallaceTreeMultpr8x8
    import mac_pkg::*;
(
    input  logic [7:0]        a,
    input  logic [7:0]        b,
    output logic [PROD_W-1:0] prod
);

    // 3:2 carry-save compressor on whole rows: returns {carry<<1, sum}.
    // Carries past bit 15 are dropped; the true product never needs them.
    function automatic logic [2*PROD_W-1:0] csa(input logic [PROD_W-1:0] x, y, z);
        return {((x & y) | (x & z) | (y & z)) << 1, x ^ y ^ z};
    endfunction

    logic [PROD_W-1:0] pp [8];
    logic [PROD_W-1:0] s  [6];
    logic [PROD_W-1:0] c  [6];

    // 8 rows -> 6 -> 4 -> 3 -> 2, then one carry-propagate add.
    always_comb begin
        for (int i = 0; i < 8; i++) pp[i] = {8'b0, a & {8{b[i]}}} << i;
        {c[0], s[0]} = csa(pp[0], pp[1], pp[2]);
        {c[1], s[1]} = csa(pp[3], pp[4], pp[5]);
        {c[2], s[2]} = csa(s[0], c[0], s[1]);
        {c[3], s[3]} = csa(c[1], pp[6], pp[7]);
        {c[4], s[4]} = csa(s[2], c[2], s[3]);
        {c[5], s[5]} = csa(s[4], c[4], c[3]);
        prod = s[5] + c[5];
    end

endmodule

// File: rtl/wallace_mac_accum.sv
// wallace_mac_accum: pipelined multiply-accumulate, one result per in_last-terminated group.
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - wallace_mac_accum_if.slave (operand stream in, group result out, clear)
// Optional: define MAC_SAT_EN to saturate the accumulator to all ones on overflow
// (for the rest of the group); otherwise it wraps and out_ovf is the only indication.
module wallace_mac_accum
    import mac_pkg::*;
#(
    parameter int ACC_W     = 24,
    parameter int MAX_TERMS = 256,
    parameter int CNT_W     = cnt_width(MAX_TERMS)
) (
    input logic                clk,
    input logic                rst,
    wallace_mac_accum_if.slave bus
);

    logic              s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [7:0]        s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic              s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic [PROD_W-1:0] s2_prod_q, s2_prod_d;
    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
    logic [ACC_W-1:0]  out_acc_q, out_acc_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;

    logic              stall, accept, close, new_ovf;
    logic [PROD_W-1:0] prod;
    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  new_acc;
    logic [CNT_W-1:0]  new_cnt;

    WallaceTreeMultpr8x8 u_mult (
        .a    (s1_a_q),
        .b    (s1_b_q),
        .prod (prod)
    );

    assign stall        = out_valid_q & ~bus.out_ready;
    assign bus.in_ready = ~stall & ~bus.clear;
    assign accept       = bus.in_valid & bus.in_ready;

    // In EMPTY the running values are ignored so a new group starts from the product alone.
    assign sum     = {1'b0, (state_q == EMPTY) ? '0 : acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, s2_prod_q};
    assign new_cnt = ((state_q == EMPTY) ? '0 : cnt_q) + CNT_W'(1);
    assign new_ovf = ((state_q == EMPTY) ? 1'b0 : ovf_q) | sum[ACC_W];
    assign close   = s2_last_q | (new_cnt == CNT_W'(MAX_TERMS));
`ifdef MAC_SAT_EN
    assign new_acc = new_ovf ? '1 : sum[ACC_W-1:0];
`else
    assign new_acc = sum[ACC_W-1:0];
`endif

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s2_valid_d  = s2_valid_q;
        s2_last_d   = s2_last_q;
        s2_prod_d   = s2_prod_q;
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q & ~bus.out_ready;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        if (bus.clear) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            state_d    = EMPTY;
            acc_d      = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
        end else if (!stall) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_a_d    = bus.in_a;
                s1_b_d    = bus.in_b;
                s1_last_d = bus.in_last;
            end
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            s2_prod_d  = prod;
            if (s2_valid_q) begin
                state_d = close ? EMPTY : PARTIAL;
                acc_d   = close ? '0 : new_acc;
                cnt_d   = close ? '0 : new_cnt;
                ovf_d   = close ? 1'b0 : new_ovf;
                if (close) begin
                    out_valid_d = 1'b1;
                    out_acc_d   = new_acc;
                    out_count_d = new_cnt;
                    out_ovf_d   = new_ovf;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_prod_q   <= '0;
            state_q     <= EMPTY;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_prod_q   <= s2_prod_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_wallace_mac_accum.sv
// tb_wallace_mac_accum: scoreboard bench for wallace_mac_accum (ACC_W=16, MAX_TERMS=4).
module tb_wallace_mac_accum;
    import mac_pkg::*;

    localparam int ACC_W     = 16;
    localparam int MAX_TERMS = 4;
    localparam int CNT_W     = cnt_width(MAX_TERMS);

    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wallace_mac_accum_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    wallace_mac_accum #(.ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    res_t exp_q[$];
    res_t got_q[$];
    res_t mon_got, mon_exp;
    int   checks = 0;
    int   errors = 0;
    int   m_acc, m_cnt;
    bit   m_ovf, m_open;

    // Scoreboard: every accepted result is compared with the model's next expected group.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            mon_got = '{bus.out_acc, bus.out_count, bus.out_ovf};
            got_q.push_back(mon_got);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: unexpected result acc=%h count=%0d ovf=%0b, none required",
                         mon_got.acc, mon_got.cnt, mon_got.ovf);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL scoreboard: got acc=%h count=%0d ovf=%0b required acc=%h count=%0d ovf=%0b",
                             mon_got.acc, mon_got.cnt, mon_got.ovf, mon_exp.acc, mon_exp.cnt, mon_exp.ovf);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before finish");
        $fatal(1);
    end

    task automatic model(input logic [7:0] a, b, input logic last);
        int s;
        s     = (m_open ? m_acc : 0) + int'(a) * int'(b);
        m_cnt = (m_open ? m_cnt : 0) + 1;
        m_ovf = (m_open ? m_ovf : 1'b0) | (s >= (1 << ACC_W));
`ifdef MAC_SAT_EN
        m_acc = m_ovf ? (1 << ACC_W) - 1 : s;
`else
        m_acc = s % (1 << ACC_W);
`endif
        m_open = 1'b1;
        if (last || m_cnt == MAX_TERMS) begin
            exp_q.push_back('{ACC_W'(m_acc), CNT_W'(m_cnt), m_ovf});
            m_open = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] a, b, input logic last);
        int n = 0;
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_accept: in_ready=0 for 50 cycles, required 1");
        end else model(a, b, last);
    endtask

    task automatic wait_got(input int n);
        int t = 0;
        while (got_q.size() < n && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (got_q.size() < n) begin
            errors++;
            $display("FAIL wait_results: got %0d results, required %0d", got_q.size(), n);
            while (got_q.size() < n) got_q.push_back('0);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.out_acc, bus.out_count, bus.out_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b acc=%h count=%0d ovf=%0b required all 0",
                     bus.out_valid, bus.out_acc, bus.out_count, bus.out_ovf);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b required 1", bus.in_ready);
        end
    endtask

    task automatic test_single();
        res_t g;
        got_q.delete();
        send(8'hFF, 8'hFF, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency_early: out_valid=%0b in cycle N+2 required 0", bus.out_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: out_valid=%0b in cycle N+3 required 1", bus.out_valid);
        end
        wait_got(1);
        g = got_q.pop_front();
        checks++;
        if (g !== res_t'{16'hFE01, CNT_W'(1), 1'b0}) begin
            errors++;
            $display("FAIL single_term: got acc=%h count=%0d ovf=%0b required acc=fe01 count=1 ovf=0",
                     g.acc, g.cnt, g.ovf);
        end
    endtask

    task automatic test_group3();
        res_t g;
        got_q.delete();
        send(8'd3, 8'd4, 1'b0);
        send(8'd10, 8'd10, 1'b0);
        send(8'hFF, 8'd2, 1'b1);
        wait_got(1);
        g = got_q.pop_front();
        checks++;
        if (g !== res_t'{16'd622, CNT_W'(3), 1'b0}) begin
            errors++;
            $display("FAIL group3: got acc=%0d count=%0d ovf=%0b required acc=622 count=3 ovf=0",
                     g.acc, g.cnt, g.ovf);
        end
    endtask

    task automatic test_back_to_back();
        got_q.delete();
        bus.out_ready = 1'b0;
        send(8'd2, 8'd3, 1'b0);
        send(8'd4, 8'd5, 1'b1);
        send(8'd6, 8'd7, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_a     = 8'd1;
        bus.in_b     = 8'd1;
        bus.in_last  = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_acc !== 16'd26) begin
            errors++;
            $display("FAIL stall_hold: in_ready=%0b out_valid=%0b acc=%0d required 0 1 26",
                     bus.in_ready, bus.out_valid, bus.out_acc);
        end
        @(negedge clk);
        checks++;
        if (bus.out_acc !== 16'd26 || bus.out_count !== CNT_W'(2)) begin
            errors++;
            $display("FAIL stall_stable: acc=%0d count=%0d required 26 2", bus.out_acc, bus.out_count);
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_acc !== 16'd42 || bus.out_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL back_to_back: valid=%0b acc=%0d count=%0d required 1 42 1",
                     bus.out_valid, bus.out_acc, bus.out_count);
        end
        wait_got(2);
        got_q.delete();
    endtask

    task automatic test_overflow();
        res_t g;
        logic [ACC_W-1:0] want;
`ifdef MAC_SAT_EN
        want = 16'hFFFF;
`else
        want = 16'hFC02;
`endif
        got_q.delete();
        send(8'hFF, 8'hFF, 1'b0);
        send(8'hFF, 8'hFF, 1'b1);
        wait_got(1);
        g = got_q.pop_front();
        checks++;
        if (g !== res_t'{want, CNT_W'(2), 1'b1}) begin
            errors++;
            $display("FAIL overflow: got acc=%h count=%0d ovf=%0b required acc=%h count=2 ovf=1",
                     g.acc, g.cnt, g.ovf, want);
        end
    endtask

    task automatic test_force_close();
        res_t g;
        got_q.delete();
        for (int i = 0; i < 6; i++) send(8'd1, 8'd1, i == 5);
        wait_got(2);
        g = got_q.pop_front();
        checks++;
        if (g !== res_t'{16'd4, CNT_W'(4), 1'b0}) begin
            errors++;
            $display("FAIL force_close_first: got acc=%0d count=%0d required acc=4 count=4", g.acc, g.cnt);
        end
        g = got_q.pop_front();
        checks++;
        if (g !== res_t'{16'd2, CNT_W'(2), 1'b0}) begin
            errors++;
            $display("FAIL force_close_second: got acc=%0d count=%0d required acc=2 count=2", g.acc, g.cnt);
        end
    endtask

    task automatic test_clear();
        res_t g;
        got_q.delete();
        send(8'd1, 8'd2, 1'b0);
        send(8'd3, 8'd4, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_a     = 8'd9;
        bus.in_b     = 8'd9;
        bus.in_last  = 1'b1;
        bus.clear    = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_in_ready: got %0b required 0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        m_open       = 1'b0;
        send(8'd5, 8'd5, 1'b1);
        wait_got(1);
        g = got_q.pop_front();
        checks++;
        if (g !== res_t'{16'd25, CNT_W'(1), 1'b0}) begin
            errors++;
            $display("FAIL clear_group: got acc=%0d count=%0d ovf=%0b required acc=25 count=1 ovf=0",
                     g.acc, g.cnt, g.ovf);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        send(8'd7, 8'd7, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_acc, bus.out_count, bus.out_ovf} !== '0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: valid=%0b acc=%h count=%0d ovf=%0b in_ready=%0b required 0 0 0 0 1",
                     bus.out_valid, bus.out_acc, bus.out_count, bus.out_ovf, bus.in_ready);
        end
        exp_q.delete();
        m_open = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_spurious: out_valid=1 after reset, required 0");
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b1;
        m_acc  = 0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_open = 1'b0;
        test_reset();
        test_single();
        test_group3();
        test_back_to_back();
        test_overflow();
        test_force_close();
        test_clear();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
